piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 51 +++++
 rtl/piso_serializer_bit_timer.sv | 46 ++++
 rtl/piso_serializer.sv | 170 +++++++++++++++++
 tb/tb_piso_serializer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer.
//   state_t             - FSM state encoding. PARITY exists only when
//                         PISO_SERIALIZER_PARITY_EN is defined.
//   frame_cycles_plain  - frame length in clocks without a parity bit.
//   frame_cycles_parity - frame length in clocks with a parity bit.
//   frame_cycles        - frame length for the current build.
//   cnt_width           - counter width for a 0..n-1 counter (at least 1 bit).
// Optional feature macro: PISO_SERIALIZER_PARITY_EN.
package piso_pkg;

`ifdef PISO_SERIALIZER_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd4
   } state_t;
`endif

   function automatic int unsigned frame_cycles_plain(input int unsigned width,
                                                      input int unsigned bit_cycles);
      return (width + 2) * bit_cycles;
   endfunction

   function automatic int unsigned frame_cycles_parity(input int unsigned width,
                                                       input int unsigned bit_cycles);
      return (width + 3) * bit_cycles;
   endfunction

   function automatic int unsigned frame_cycles(input int unsigned width,
                                                input int unsigned bit_cycles);
`ifdef PISO_SERIALIZER_PARITY_EN
      return frame_cycles_parity(width, bit_cycles);
`else
      return frame_cycles_plain(width, bit_cycles);
`endif
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/piso_serializer_bit_timer.sv
// Bit timer for the PISO serializer: counts 0..BIT_CYCLES-1 and wraps on
// each bit boundary.
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   clear     - hold the count at 0 (used while the serializer is idle)
//   tick      - high during the last cycle of each bit period
//   tick_next - tick will be high in the following cycle; lets the parent
//               register outputs that must line up with tick
module bit_timer
   import piso_pkg::*;
#(
   parameter int unsigned BIT_CYCLES = 4
)(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick,
   output logic tick_next
);

   localparam int unsigned    CW   = cnt_width(BIT_CYCLES);
   localparam logic [CW-1:0]  LAST = CW'(BIT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   assign tick_next = (cnt_d == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer. A frame is a start bit (0), WIDTH data
// bits LSB first, an optional even-parity bit, and a stop bit (1). Each bit
// is held for BIT_CYCLES clocks. All outputs come straight from flops.
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset; aborts any frame without done
//   din   - parallel word, captured only when a load is accepted
//   load  - transmit request, accepted when ready is high
//   ready - idle, a load will be accepted
//   sout  - serial line, idle high
//   busy  - frame in progress (inverse of ready)
//   done  - one-cycle pulse in the final stop-bit cycle
// Optional feature macro: PISO_SERIALIZER_PARITY_EN adds the parity bit.
//
// state  | meaning
// IDLE   | line high, waiting for load
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | even-parity bit (parity builds only)
// STOP   | stop bit (1), done in its last cycle
module piso_serializer
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned BIT_CYCLES = 4
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             load,
   output logic             ready,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam int unsigned   BW       = cnt_width(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             sout_q, sout_d;
   logic             done_q, done_d;
   logic             ready_q, ready_d;
   logic             busy_q;
`ifdef PISO_SERIALIZER_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic tick;
   logic tick_next;
   logic timer_clear;

   // Holding the timer in clear while idle makes the start bit begin at
   // count 0 on the cycle after acceptance.
   assign timer_clear = (state_q == IDLE);

   bit_timer #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_bit_timer (
      .clk       (clk),
      .rst       (rst),
      .clear     (timer_clear),
      .tick      (tick),
      .tick_next (tick_next)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_d  = parity_q;
`endif

      case (state_q)
         IDLE: begin
            if (load) begin
               state_d   = START;
               shift_d   = din;
               bit_cnt_d = '0;
`ifdef PISO_SERIALIZER_PARITY_EN
               parity_d  = ^din;
`endif
            end
         end
         START: begin
            if (tick) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_cnt_q == LAST_BIT) begin
`ifdef PISO_SERIALIZER_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  shift_d   = shift_q >> 1;
               end
            end
         end
`ifdef PISO_SERIALIZER_PARITY_EN
         PARITY: begin
            if (tick) begin
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are derived from the next state so that they are registered
      // yet aligned with the state they describe.
      case (state_d)
         START:   sout_d = 1'b0;
         DATA:    sout_d = shift_d[0];
`ifdef PISO_SERIALIZER_PARITY_EN
         PARITY:  sout_d = parity_d;
`endif
         default: sout_d = 1'b1;
      endcase

      done_d  = (state_d == STOP) && tick_next;
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         sout_q    <= 1'b1;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         sout_q    <= sout_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
         busy_q    <= ~ready_d;
`ifdef PISO_SERIALIZER_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign sout  = sout_q;
   assign done  = done_q;
   assign ready = ready_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (WIDTH=8, BIT_CYCLES=4).
// Honours PISO_SERIALIZER_PARITY_EN for the expected frame layout.
module tb_piso_serializer;

   localparam int W  = 8;
   localparam int BC = 4;
`ifdef PISO_SERIALIZER_PARITY_EN
   localparam int NSLOT  = W + 3;
   localparam bit PAR_ON = 1'b1;
`else
   localparam int NSLOT  = W + 2;
   localparam bit PAR_ON = 1'b0;
`endif
   localparam int FLEN = NSLOT * BC;

   logic         clk = 1'b0;
   logic         rst;
   logic         load;
   logic [W-1:0] din;
   logic         ready, sout, busy, done;

   piso_serializer #(.WIDTH(W), .BIT_CYCLES(BC)) dut (
      .clk   (clk),
      .rst   (rst),
      .din   (din),
      .load  (load),
      .ready (ready),
      .sout  (sout),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: queue of {sout, done} for every upcoming frame cycle.
   // An empty queue means the line is idle.
   logic [1:0] exp_q[$];

   typedef struct {
      logic [7:0] din;
      logic [7:0] tx_order;   // bit 7 is the first data bit on the wire
      logic       par;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_push(input logic [W-1:0] d);
      logic b;
      for (int s = 0; s < NSLOT; s++) begin
         if (s == 0)                       b = 1'b0;
         else if (s <= W)                  b = d[s-1];
         else if (PAR_ON && s == W + 1)    b = ($countones(d) % 2) == 1;
         else                              b = 1'b1;
         for (int k = 0; k < BC; k++) begin
            exp_q.push_back({b, (s == NSLOT - 1) && (k == BC - 1)});
         end
      end
   endtask

   // One clock: update the model from the inputs seen at the edge, then
   // compare all outputs half a cycle later.
   task automatic step();
      bit         was_idle;
      logic [1:0] dummy;
      logic       e_sout, e_done, e_ready;
      @(posedge clk);
      was_idle = (exp_q.size() == 0);
      if (rst)           exp_q.delete();
      else if (!was_idle) dummy = exp_q.pop_front();
      else if (load)     model_push(din);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         e_sout = 1'b1; e_done = 1'b0; e_ready = 1'b1;
      end else begin
         e_sout = exp_q[0][1]; e_done = exp_q[0][0]; e_ready = 1'b0;
      end
      chk("sout",  sout,  e_sout);
      chk("done",  done,  e_done);
      chk("ready", ready, e_ready);
      chk("busy",  busy,  !e_ready);
   endtask

   // Send one table vector and check its waveform slot by slot. A nonzero
   // glitch_at pulses load with 8'hFF during that frame cycle.
   task automatic run_vector(input vec_t v, input int glitch_at);
      logic [FLEN:1] cap;
      logic [BC-1:0] got;
      logic          eb;
      int            n_done, done_at;
      din = v.din; load = 1'b1;
      step();
      load = 1'b0;
      n_done = 0; done_at = 0;
      for (int c = 1; c <= FLEN; c++) begin
         cap[c] = sout;
         if (done) begin n_done++; done_at = c; end
         if (c == glitch_at) begin load = 1'b1; din = 8'hFF; end
         step();
         if (c == glitch_at) begin load = 1'b0; din = v.din; end
      end
      for (int s = 0; s < NSLOT; s++) begin
         if (s == 0)                    eb = 1'b0;
         else if (s <= W)               eb = v.tx_order[W-s];
         else if (PAR_ON && s == W + 1) eb = v.par;
         else                           eb = 1'b1;
         for (int k = 0; k < BC; k++) got[k] = cap[s*BC + k + 1];
         chk($sformatf("din %h slot %0d", v.din, s), got, {BC{eb}});
      end
      chk($sformatf("din %h done_at", v.din), done_at, FLEN);
      chk($sformatf("din %h done_count", v.din), n_done, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n_done, n_idle, idle_at;
      vecs[0] = '{8'hA5, 8'b10100101, 1'b0};
      vecs[1] = '{8'h3C, 8'b00111100, 1'b0};
      vecs[2] = '{8'h01, 8'b10000000, 1'b1};
      vecs[3] = '{8'h80, 8'b00000001, 1'b1};
      vecs[4] = '{8'hF0, 8'b00001111, 1'b0};
      vecs[5] = '{8'h6E, 8'b01110110, 1'b1};

      rst = 1'b1; load = 1'b0; din = '0;
      step(); step();
      rst = 1'b0;
      repeat (10) step();

      // load coincident with reset is dropped
      rst = 1'b1; load = 1'b1; din = 8'h55;
      step();
      rst = 1'b0; load = 1'b0;
      chk("rst_load_ready", ready, 1);
      chk("rst_load_sout", sout, 1);
      repeat (3) step();

      for (int i = 0; i < 6; i++) run_vector(vecs[i], 0);

      // load with 8'hFF during cycle 10 of a 8'h3C frame is ignored
      run_vector(vecs[1], 10);

      // reset during cycle 17 of a frame
      din = 8'h3C; load = 1'b1;
      step();
      load = 1'b0;
      n_done = 0;
      for (int c = 1; c <= 17; c++) begin
         if (done) n_done++;
         if (c == 17) rst = 1'b1;
         step();
      end
      rst = 1'b0;
      chk("abort_sout", sout, 1);
      chk("abort_ready", ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_no_done", n_done + int'(done), 0);
      repeat (3) step();
      run_vector(vecs[2], 0);

      // load held high across two frames
      din = 8'h5A; load = 1'b1;
      step();
      n_done = 0; n_idle = 0; idle_at = 0;
      for (int c = 1; c <= 2*FLEN + 1; c++) begin
         if (done) n_done++;
         if (ready) begin n_idle++; idle_at = c; end
         if (c == FLEN) din = 8'hC3;
         if (c == 2*FLEN + 1) load = 1'b0;
         step();
      end
      chk("b2b_done_count", n_done, 2);
      chk("b2b_idle_cycles", n_idle, 1);
      chk("b2b_idle_at", idle_at, FLEN + 1);
      repeat (2) step();

      // randomized traffic against the model
      for (int it = 0; it < 25; it++) begin
         int gap, rst_at;
         gap = $urandom_range(0, 3);
         load = 1'b0;
         repeat (gap) step();
         din = W'($urandom); load = 1'b1;
         step();
         rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, FLEN)) : 0;
         for (int c = 1; c <= FLEN; c++) begin
            load = ($urandom_range(0, 7) == 0);
            din  = W'($urandom);
            rst  = (c == rst_at);
            step();
         end
         rst = 1'b0;
      end
      load = 1'b0;
      repeat (FLEN + 2) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
